ecliptic_converter_to_int: RTL and testbench

//  FP32 -> 32-bit integer converter (RISC-V FCVT.W.S / FCVT.WU.S). It is the return-path counterpart
//  of ecliptic_converter_from_int and sits beside it and the other ecliptic execution units.

---
 rtl/ecliptic_pkg.sv | 52 +++++
 rtl/ecliptic_round_inc.sv | 32 +++
 rtl/ecliptic_converter_to_int.sv | 211 +++++++++++++++++++++
 tb/tb_ecliptic_converter_to_int.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecliptic_pkg.sv
// ecliptic_pkg
//   Shared types and constants for the ecliptic execution units.
//   - rm_e      : RISC-V rounding-mode encoding (codes 5..7 are reserved)
//   - fp32_s    : IEEE-754 binary32 field view
//   - fpcls_e   : operand class produced by fp32Class()
//   - FP32_BIAS, INT32_MAX, INT32_MIN, UINT32_MAX
package ecliptic_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_s;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUB,
    FP_NORM,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fpcls_e;

  localparam int          FP32_BIAS  = 127;
  localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

  // Class of a binary32 operand; shared with ecliptic_classification.
  function automatic fpcls_e fp32Class(input fp32_s x);
    fpcls_e c;
    if (x.exp == 8'hFF) begin
      if (x.frac == '0)     c = FP_INF;
      else if (x.frac[22])  c = FP_QNAN;
      else                  c = FP_SNAN;
    end else if (x.exp == 8'h00) begin
      c = (x.frac == '0) ? FP_ZERO : FP_SUB;
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/ecliptic_round_inc.sv
// ecliptic_round_inc
//   Combinational round-increment decision shared by the ecliptic rounding units.
//   Ports:
//     sign      in  1  sign of the value being rounded
//     lsb       in  1  least significant kept bit of the magnitude
//     guard     in  1  first discarded bit
//     sticky    in  1  OR of all remaining discarded bits
//     rm        in  3  rounding mode (rm_e); reserved codes round as RNE
//     increment out 1  1 when the magnitude must be bumped by one ulp
module ecliptic_round_inc
  import ecliptic_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  input  logic [2:0] rm,
  output logic       increment
);

  always_comb begin
    increment = 1'b0;
    case (rm_e'(rm))
      RTZ:     increment = 1'b0;
      RDN:     increment = sign & (guard | sticky);
      RUP:     increment = ~sign & (guard | sticky);
      RMM:     increment = guard;
      default: increment = guard & (sticky | lsb);
    endcase
  end

endmodule

// File: rtl/ecliptic_converter_to_int.sv
// ecliptic_converter_to_int
//   FP32 -> int32/uint32 converter (FCVT.W.S / FCVT.WU.S), fully pipelined,
//   one request per cycle, fixed latency 2 (OUT_REG=0) or 3 (OUT_REG=1).
//   Macro ECLIPTIC_DYNAMIC_ROUNDING_EN: when defined rm is honoured; when
//   undefined every conversion truncates (RTZ) and rm is ignored.
//   Ports:
//     clk          in  1   clock, rising edge
//     nrst         in  1   asynchronous active-low reset
//     req          in  1   request valid; operands sampled when 1
//     src          in  32  binary32 operand
//     dst_unsigned in  1   1: uint32 result, 0: int32 result
//     rm           in  3   rounding mode (rm_e)
//     ack          out 1   one-cycle result valid per request
//     res          out 32  saturated integer result (0 when ack=0)
//     invalid      out 1   NV flag (0 when ack=0)
//     inexact      out 1   NX flag (0 when ack=0)
module ecliptic_converter_to_int
  import ecliptic_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req,
  input  logic [31:0] src,
  input  logic        dst_unsigned,
  input  logic [2:0]  rm,
  output logic        ack,
  output logic [31:0] res,
  output logic        invalid,
  output logic        inexact
);

  typedef struct packed {
    logic [31:0] res;
    logic        inv;
    logic        inx;
  } cvt_s;

  // Overflow/NaN clamping and flag generation on the rounded magnitude.
  function automatic cvt_s saturate(input logic        sign,
                                    input logic        isNan,
                                    input logic        isOvf,
                                    input logic        uns,
                                    input logic [32:0] mag,
                                    input logic        lost);
    cvt_s r;
    r = '0;
    if (isNan) begin
      r.inv = 1'b1;
      r.res = uns ? UINT32_MAX : INT32_MAX;
    end else if (uns) begin
      if (sign) begin
        // Negative values that survive rounding as nonzero are out of range.
        r.inv = isOvf || (mag != '0);
      end else if (isOvf || mag[32]) begin
        r.inv = 1'b1;
        r.res = UINT32_MAX;
      end else begin
        r.res = mag[31:0];
      end
    end else begin
      if (sign) begin
        if (isOvf || (mag > 33'h0_8000_0000)) begin
          r.inv = 1'b1;
          r.res = INT32_MIN;
        end else begin
          r.res = 32'd0 - mag[31:0];
        end
      end else if (isOvf || (mag > 33'h0_7FFF_FFFF)) begin
        r.inv = 1'b1;
        r.res = INT32_MAX;
      end else begin
        r.res = mag[31:0];
      end
    end
    r.inx = lost && !r.inv;
    return r;
  endfunction

  // ---- stage p0 -> p1: unpack and classify ----
  fp32_s              srcF;
  logic               vld_p1;
  logic               sign_p1;
  fpcls_e             cls_p1;
  logic signed [9:0]  expUnb_p1;
  logic [22:0]        frac_p1;
  logic               uns_p1;

  assign srcF = src;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) vld_p1 <= 1'b0;
    else       vld_p1 <= req;
  end

  always_ff @(posedge clk) begin
    if (req) begin
      sign_p1   <= srcF.sign;
      cls_p1    <= fp32Class(srcF);
      expUnb_p1 <= $signed({2'b00, srcF.exp}) - 10'sd127;
      frac_p1   <= srcF.frac;
      uns_p1    <= dst_unsigned;
    end
  end

`ifdef ECLIPTIC_DYNAMIC_ROUNDING_EN
  logic [2:0] rm_p1;
  always_ff @(posedge clk) begin
    if (req) rm_p1 <= rm;
  end
`else
  logic unusedRm;
  assign unusedRm = ^rm;
`endif

  // ---- stage p1 -> p2: align, round, negate, saturate ----
  logic        isNan;
  logic        isOvf;
  logic [4:0]  shAmt;
  logic [63:0] wide;
  logic [31:0] mag;
  logic        guard;
  logic        sticky;
  logic        inc;
  logic [32:0] magRnd;
  cvt_s        cvt;
  logic        vld_p2;
  cvt_s        out_p2;

  assign isNan = (cls_p1 == FP_QNAN) || (cls_p1 == FP_SNAN);
  assign isOvf = (cls_p1 == FP_INF) ||
                 ((cls_p1 == FP_NORM) && (expUnb_p1 >= 10'sd32));
  // Only meaningful for 0 <= e <= 31, where 31-e fits five bits.
  assign shAmt = 5'd31 - expUnb_p1[4:0];
  assign wide  = {1'b1, frac_p1, 40'd0} >> shAmt;

  always_comb begin
    mag    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    if ((cls_p1 == FP_ZERO) || (cls_p1 == FP_SUB)) begin
      sticky = |frac_p1;
    end else if (cls_p1 == FP_NORM) begin
      if (expUnb_p1 < 10'sd0) begin
        // |x| < 1: the hidden bit is the guard only when e = -1.
        guard  = (expUnb_p1 == -10'sd1);
        sticky = (expUnb_p1 == -10'sd1) ? |frac_p1 : 1'b1;
      end else if (expUnb_p1 < 10'sd32) begin
        mag    = wide[63:32];
        guard  = wide[31];
        sticky = |wide[30:0];
      end
    end
  end

`ifdef ECLIPTIC_DYNAMIC_ROUNDING_EN
  ecliptic_round_inc uRoundInc (
    .sign      (sign_p1),
    .lsb       (mag[0]),
    .guard     (guard),
    .sticky    (sticky),
    .rm        (rm_p1),
    .increment (inc)
  );
`else
  assign inc = 1'b0;
`endif

  assign magRnd = {1'b0, mag} + {32'd0, inc};
  assign cvt    = saturate(sign_p1, isNan, isOvf, uns_p1, magRnd, guard | sticky);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    out_p2 <= cvt;
  end

  // ---- stage p2 -> p3: optional output register ----
  logic vldOut;
  cvt_s outSel;

  generate
    if (OUT_REG != 0) begin : gOutReg
      logic vld_p3;
      cvt_s out_p3;
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) vld_p3 <= 1'b0;
        else       vld_p3 <= vld_p2;
      end
      always_ff @(posedge clk) begin
        out_p3 <= out_p2;
      end
      assign vldOut = vld_p3;
      assign outSel = out_p3;
    end else begin : gNoOutReg
      assign vldOut = vld_p2;
      assign outSel = out_p2;
    end
  endgenerate

  // Data registers are not reset; gating by the valid bit keeps idle outputs at 0.
  assign ack     = vldOut;
  assign res     = vldOut ? outSel.res : '0;
  assign invalid = vldOut & outSel.inv;
  assign inexact = vldOut & outSel.inx;

endmodule

// File: tb/tb_ecliptic_converter_to_int.sv
// tb_ecliptic_converter_to_int
//   Randomized bench with an arithmetic reference model: the operand is
//   taken as an exact rational m*2^k, split into integer part and remainder,
//   rounded by comparing the remainder with one half, then range-checked.
module tb_ecliptic_converter_to_int;

  localparam int OUT_REG = 1;
  localparam int LAT     = 2 + OUT_REG;

  logic        clk;
  logic        nrst;
  logic        req;
  logic [31:0] src;
  logic        dstUns;
  logic [2:0]  rm;
  logic        ack;
  logic [31:0] res;
  logic        invalid;
  logic        inexact;

  int checks   = 0;
  int failures = 0;
  bit running  = 1'b0;

  ecliptic_converter_to_int #(.OUT_REG(OUT_REG)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req          (req),
    .src          (src),
    .dst_unsigned (dstUns),
    .rm           (rm),
    .ack          (ack),
    .res          (res),
    .invalid      (invalid),
    .inexact      (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {res, invalid, inexact}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic uns,
                                        input logic [2:0] mode);
    logic         sgn;
    int           ex;
    int           k;
    logic [22:0]  fr;
    logic [23:0]  m;
    logic [127:0] ip, rem, half;
    logic         up, nan, inv;
    logic [31:0]  r;
    sgn = x[31];
    ex  = int'(x[30:23]);
    fr  = x[22:0];
    nan = (ex == 255) && (fr != 0);
    if (ex == 255) begin
      ip = 128'd1 << 100; rem = 0; half = 1;
    end else begin
      m = (ex == 0) ? {1'b0, fr} : {1'b1, fr};
      k = (ex == 0) ? -149 : ex - 150;
      if (k >= 0) begin
        ip = 128'(m) << k; rem = 0; half = 1;
      end else if (k < -100) begin
        ip = 0; rem = 128'(m); half = 128'd1 << 100;
      end else begin
        ip   = 128'(m) >> (-k);
        rem  = 128'(m) & ((128'd1 << (-k)) - 128'd1);
        half = 128'd1 << (-k - 1);
      end
    end
    case (mode)
      3'd1:    up = 1'b0;
      3'd2:    up = sgn && (rem != 0);
      3'd3:    up = !sgn && (rem != 0);
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && ip[0]);
    endcase
    ip  = ip + 128'(up);
    inv = 1'b0;
    r   = 32'd0;
    if (nan) begin
      inv = 1'b1; r = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    end else if (uns) begin
      if (sgn) inv = (ip != 0);
      else if (ip > 128'hFFFF_FFFF) begin inv = 1'b1; r = 32'hFFFF_FFFF; end
      else r = ip[31:0];
    end else begin
      if (!sgn && ip > 128'h7FFF_FFFF) begin inv = 1'b1; r = 32'h7FFF_FFFF; end
      else if (sgn && ip > 128'h8000_0000) begin inv = 1'b1; r = 32'h8000_0000; end
      else r = sgn ? (32'd0 - ip[31:0]) : ip[31:0];
    end
    return {r, inv, !inv && (rem != 0)};
  endfunction

  function automatic logic [2:0] effRm(input logic [2:0] mode);
`ifdef ECLIPTIC_DYNAMIC_ROUNDING_EN
    return mode;
`else
    return mode & 3'd0 | 3'd1;
`endif
  endfunction

  typedef struct packed {
    logic        v;
    logic [33:0] d;
  } exp_t;

  exp_t pipe [LAT];

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= req ? {1'b1, model(src, dstUns, effRm(rm))} : '0;
    end
  end

  always @(negedge clk) begin
    if (running) begin
      exp_t e;
      e = pipe[LAT-1];
      checks++;
      if (ack !== e.v || res !== e.d[33:2] || invalid !== e.d[1] || inexact !== e.d[0]) begin
        failures++;
        $display("FAIL out t=%0t got ack=%b res=%h nv=%b nx=%b want ack=%b res=%h nv=%b nx=%b",
                 $time, ack, res, invalid, inexact, e.v, e.d[33:2], e.d[1], e.d[0]);
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] x, input logic uns,
                     input logic [2:0] mode, input logic [31:0] wr,
                     input logic wnv, input logic wnx);
    logic [33:0] got;
    got = model(x, uns, mode);
    checks++;
    if (got !== {wr, wnv, wnx}) begin
      failures++;
      $display("FAIL pin %s got res=%h nv=%b nx=%b want res=%h nv=%b nx=%b",
               name, got[33:2], got[1], got[0], wr, wnv, wnx);
    end
  endtask

  task automatic send(input logic [31:0] x, input logic uns, input logic [2:0] mode);
    req = 1'b1; src = x; dstUns = uns; rm = mode;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  logic [31:0] dirSrc [15] = '{32'h3FC00000, 32'h3FC00000, 32'hBFC00000, 32'hBFC00000,
                               32'hBFC00000, 32'h7F800001, 32'h7F800001, 32'hFF800000,
                               32'hCF000000, 32'h4F000000, 32'h4F000000, 32'hC0400000,
                               32'hBE99999A, 32'hBE99999A, 32'h4EFFFFFF};
  logic        dirUns [15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0};
  logic [2:0]  dirRm  [15] = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0};

  initial begin
    nrst = 1'b0; req = 1'b0; src = '0; dstUns = 1'b0; rm = '0;
    running = 1'b1;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    pin("rne_1p5",    32'h3FC00000, 0, 3'd0, 32'h00000002, 0, 1);
    pin("rtz_1p5",    32'h3FC00000, 0, 3'd1, 32'h00000001, 0, 1);
    pin("rdn_m1p5",   32'hBFC00000, 0, 3'd2, 32'hFFFFFFFE, 0, 1);
    pin("rup_m1p5",   32'hBFC00000, 0, 3'd3, 32'hFFFFFFFF, 0, 1);
    pin("rmm_m1p5",   32'hBFC00000, 0, 3'd4, 32'hFFFFFFFE, 0, 1);
    pin("snan_s",     32'h7F800001, 0, 3'd0, 32'h7FFFFFFF, 1, 0);
    pin("snan_u",     32'h7F800001, 1, 3'd0, 32'hFFFFFFFF, 1, 0);
    pin("ninf_s",     32'hFF800000, 0, 3'd0, 32'h80000000, 1, 0);
    pin("min_s",      32'hCF000000, 0, 3'd0, 32'h80000000, 0, 0);
    pin("two31_s",    32'h4F000000, 0, 3'd0, 32'h7FFFFFFF, 1, 0);
    pin("two31_u",    32'h4F000000, 1, 3'd0, 32'h80000000, 0, 0);
    pin("m3_u",       32'hC0400000, 1, 3'd0, 32'h00000000, 1, 0);
    pin("m0p3_rtz_u", 32'hBE99999A, 1, 3'd1, 32'h00000000, 0, 1);
    pin("m0p3_rdn_u", 32'hBE99999A, 1, 3'd2, 32'h00000000, 1, 0);
    pin("big_exact",  32'h4EFFFFFF, 0, 3'd0, 32'h7FFFFF80, 0, 0);
    pin("rne_tie_2p5",32'h40200000, 0, 3'd0, 32'h00000002, 0, 1);

    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) send(dirSrc[i], dirUns[i], dirRm[i]);
    repeat (LAT + 1) @(posedge clk);
    #1;

    for (int i = 0; i < 600; i++) begin
      logic [31:0] x;
      int cat;
      cat = int'($urandom_range(0, 9));
      x = $urandom;
      if (cat < 6) x[30:23] = 8'($urandom_range(100, 162));
      else if (cat == 6) x[30:23] = 8'hFF;
      else if (cat == 7) x[30:23] = 8'h00;
      else if (cat == 8) x[22:0] = $urandom_range(0, 1) ? 23'h400000 : 23'h0;
      if ($urandom_range(0, 3) != 0) send(x, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      else begin @(posedge clk); #1; end
    end
    repeat (LAT + 1) @(posedge clk);
    #1;

    // Reset in the middle of a burst of four requests.
    send(32'h3FC00000, 0, 3'd0);
    send(32'h40400000, 0, 3'd0);
    req = 1'b1; src = 32'hC0400000; dstUns = 1'b0; rm = 3'd1;
    #2 nrst = 1'b0;
    @(posedge clk); #1;
    src = 32'h41200000;
    @(posedge clk); #1;
    req = 1'b0;
    #1 nrst = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    send(32'h42C80000, 0, 3'd0);
    repeat (LAT + 2) @(posedge clk);
    #1;

    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
